// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-addressed memory bus master: default widths,
// FSM state encoding and the byte-lane width helper.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  function automatic int byte_width(input int data_w);
    return data_w / 2;
  endfunction

  localparam int BYTE_W = byte_width(DATA_W_DEF);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_HI   = 3'd3,
    S_WR_LO   = 3'd4
  } state_t;

endpackage

// File: rtl/mem_master.sv
// Memory bus master: word reads (3-cycle REQ-to-DONE), word/byte writes over a shared
// tristate DATA bus; requests are taken only in IDLE, ignored while BUSY, never queued.
module mem_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic              BYTE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] ADDR,
  output logic              MSL,
  output logic              MOE,
  output logic              MWE,
  inout  wire  [DATA_W-1:0] DATA
);

  localparam int BW = byte_width(DATA_W);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              byte_q;
  logic              data_oe;
  logic [DATA_W-1:0] data_q;

  // The master only drives the bus together with MWE, so it can never fight the memory.
  assign DATA = data_oe ? data_q : {DATA_W{1'bz}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      byte_q  <= 1'b0;
      data_oe <= 1'b0;
      data_q  <= '0;
      RDATA   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      ADDR    <= '0;
      MSL     <= 1'b0;
      MOE     <= 1'b0;
      MWE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ) begin
            // A word at the top address would need a byte past the end of memory.
            if (!(WE && BYTE) && (REQ_ADDR == {ADDR_W{1'b1}})) begin
              ERR <= 1'b1;
            end else begin
              addr_q  <= REQ_ADDR;
              wdata_q <= WDATA;
              byte_q  <= BYTE;
              ADDR    <= REQ_ADDR;
              MSL     <= 1'b1;
              BUSY    <= 1'b1;
              if (WE) begin
                state   <= S_WR_HI;
                MWE     <= 1'b1;
                data_oe <= 1'b1;
                data_q  <= BYTE ? DATA_W'(WDATA[BW-1:0]) : DATA_W'(WDATA[DATA_W-1:BW]);
              end else begin
                state <= S_RD_ADDR;
              end
            end
          end
        end
        S_RD_ADDR: begin
          MOE   <= 1'b1;
          state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          RDATA <= DATA;
          MOE   <= 1'b0;
          MSL   <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= S_IDLE;
        end
        S_WR_HI: begin
          if (byte_q) begin
            MWE     <= 1'b0;
            MSL     <= 1'b0;
            data_oe <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state   <= S_IDLE;
          end else begin
            ADDR   <= addr_q + 1'b1;
            data_q <= DATA_W'(wdata_q[BW-1:0]);
            state  <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          MWE     <= 1'b0;
          MSL     <= 1'b0;
          data_oe <= 1'b0;
          BUSY    <= 1'b0;
          DONE    <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          MSL     <= 1'b0;
          MOE     <= 1'b0;
          MWE     <= 1'b0;
          data_oe <= 1'b0;
          BUSY    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a byte-wide memory model on the shared bus.
module tb_mem_master;
  import mem_bus_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic        BYTE = 1'b0;
  logic [7:0]  REQ_ADDR = '0;
  logic [15:0] WDATA = '0;
  logic [15:0] RDATA;
  logic        BUSY, DONE, ERR, MSL, MOE, MWE;
  logic [7:0]  ADDR;
  wire  [15:0] DATA;

  int checks = 0;
  int errors = 0;

  logic [BYTE_W-1:0] mem [256];

  mem_master #(.ADDR_W(8), .DATA_W(16)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .BYTE(BYTE),
    .REQ_ADDR(REQ_ADDR), .WDATA(WDATA), .RDATA(RDATA), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .ADDR(ADDR), .MSL(MSL), .MOE(MOE), .MWE(MWE),
    .DATA(DATA)
  );

  always #5 CLK = ~CLK;

  // Memory returns a big-endian word on reads and stores the low lane on writes.
  assign DATA = (MSL && MOE) ? {mem[ADDR], mem[ADDR + 8'd1]} : 16'hzzzz;

  always @(posedge CLK) begin
    if (MSL && MWE) mem[ADDR] <= DATA[7:0];
  end

  always @(negedge CLK) begin
    if (!RST && (MOE || MWE)) begin
      checks++;
      assert (!(MOE && MWE) && !$isunknown(DATA)) else begin
        errors++;
        $error("FAIL bus_conflict obs MOE=%b MWE=%b DATA=%h exp no overlap, clean DATA", MOE, MWE, DATA);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge CLK);
  endtask

  task automatic bus_idle(input string tag);
    chk({tag, "_msl"}, 32'(MSL), 32'd0);
    chk({tag, "_moe"}, 32'(MOE), 32'd0);
    chk({tag, "_mwe"}, 32'(MWE), 32'd0);
    chk({tag, "_dataz"}, {16'h0, DATA}, {16'h0, 16'hzzzz});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 8'hAB;
    mem[8'h11] = 8'hCD;

    // Reset state
    nc();
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_addr", 32'(ADDR), 0);
    chk("rst_rdata", 32'(RDATA), 0);
    bus_idle("rst");
    RST = 1'b0;
    nc();

    // Word read at 0x10; inputs change after acceptance
    REQ = 1; WE = 0; BYTE = 0; REQ_ADDR = 8'h10;
    nc();
    chk("rd_c1_msl", 32'(MSL), 1);
    chk("rd_c1_moe", 32'(MOE), 0);
    chk("rd_c1_addr", 32'(ADDR), 32'h10);
    chk("rd_c1_busy", 32'(BUSY), 1);
    REQ = 0; REQ_ADDR = 8'h55;
    nc();
    chk("rd_c2_moe", 32'(MOE), 1);
    chk("rd_c2_addr", 32'(ADDR), 32'h10);
    chk("rd_c2_done", 32'(DONE), 0);
    nc();
    chk("rd_c3_done", 32'(DONE), 1);
    chk("rd_c3_rdata", 32'(RDATA), 32'hABCD);
    chk("rd_c3_busy", 32'(BUSY), 0);
    bus_idle("rd_c3");
    nc();
    chk("rd_c4_done", 32'(DONE), 0);
    chk("rd_c4_hold", 32'(RDATA), 32'hABCD);
    chk("rd_c4_addr", 32'(ADDR), 32'h10);

    // Word write 0x1234 to 0x20
    REQ = 1; WE = 1; BYTE = 0; REQ_ADDR = 8'h20; WDATA = 16'h1234;
    nc();
    REQ = 0; WDATA = 16'hFFFF; REQ_ADDR = 8'h00;
    chk("wr_hi_mwe", 32'(MWE), 1);
    chk("wr_hi_moe", 32'(MOE), 0);
    chk("wr_hi_addr", 32'(ADDR), 32'h20);
    chk("wr_hi_data", 32'(DATA), 32'h0012);
    nc();
    chk("wr_lo_mwe", 32'(MWE), 1);
    chk("wr_lo_addr", 32'(ADDR), 32'h21);
    chk("wr_lo_data", 32'(DATA), 32'h0034);
    nc();
    chk("wr_done", 32'(DONE), 1);
    chk("wr_rdata_hold", 32'(RDATA), 32'hABCD);
    bus_idle("wr_done");
    REQ = 1; WE = 0; REQ_ADDR = 8'h20;
    nc(); REQ = 0;
    nc(); nc();
    chk("wr_rb_done", 32'(DONE), 1);
    chk("wr_rb_rdata", 32'(RDATA), 32'h1234);

    // Byte write 0x00EE at 0xFF
    REQ = 1; WE = 1; BYTE = 1; REQ_ADDR = 8'hFF; WDATA = 16'h00EE;
    nc(); REQ = 0; BYTE = 0;
    chk("bw_mwe", 32'(MWE), 1);
    chk("bw_addr", 32'(ADDR), 32'hFF);
    chk("bw_data", 32'(DATA), 32'h00EE);
    chk("bw_err", 32'(ERR), 0);
    nc();
    chk("bw_done", 32'(DONE), 1);
    chk("bw_err2", 32'(ERR), 0);
    chk("bw_mwe_off", 32'(MWE), 0);
    chk("bw_mem", 32'(mem[8'hFF]), 32'hEE);

    // Word read at 0xFF is rejected
    REQ = 1; WE = 0; REQ_ADDR = 8'hFF;
    nc(); REQ = 0;
    chk("err_pulse", 32'(ERR), 1);
    chk("err_msl", 32'(MSL), 0);
    chk("err_busy", 32'(BUSY), 0);
    nc();
    chk("err_clear", 32'(ERR), 0);
    chk("err_busy2", 32'(BUSY), 0);
    chk("err_done", 32'(DONE), 0);

    // Word write at 0xFF is rejected too
    REQ = 1; WE = 1; BYTE = 0; REQ_ADDR = 8'hFF;
    nc(); REQ = 0;
    chk("werr_pulse", 32'(ERR), 1);
    chk("werr_mwe", 32'(MWE), 0);

    // Reset during WR_LO
    nc();
    REQ = 1; WE = 1; BYTE = 0; REQ_ADDR = 8'h20; WDATA = 16'h5678;
    nc(); REQ = 0;
    nc();
    chk("rwl_addr", 32'(ADDR), 32'h21);
    RST = 1'b1;
    #1;
    chk("rwl_busy", 32'(BUSY), 0);
    chk("rwl_addr0", 32'(ADDR), 0);
    chk("rwl_rdata0", 32'(RDATA), 0);
    bus_idle("rwl");
    nc();
    chk("rwl_nodone", 32'(DONE), 0);
    RST = 1'b0;
    REQ = 1; WE = 0; REQ_ADDR = 8'h20;
    nc(); REQ = 0;
    nc(); nc();
    chk("rwl_rd_done", 32'(DONE), 1);
    chk("rwl_rd_rdata", 32'(RDATA), 32'h5634);

    // Back-to-back reads with REQ held high
    REQ = 1; WE = 0; REQ_ADDR = 8'h10;
    for (int k = 1; k <= 9; k++) begin
      nc();
      if (k == 9) REQ = 0;
      chk($sformatf("b2b_done_%0d", k), 32'(DONE), 32'((k % 3) == 0));
      chk($sformatf("b2b_msl_%0d", k), 32'(MSL), 32'((k % 3) != 0));
      chk($sformatf("b2b_moe_%0d", k), 32'(MOE), 32'((k % 3) == 2));
      if ((k % 3) == 0) chk($sformatf("b2b_rdata_%0d", k), 32'(RDATA), 32'hABCD);
    end
    nc();
    chk("b2b_idle_busy", 32'(BUSY), 0);
    chk("b2b_idle_msl", 32'(MSL), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
